// File: rtl/dual_ram.sv
// Simple dual-port RAM: one write port, one read port, registered read data, one clock.
// Define DUAL_RAM_BYPASS_EN for write-first forwarding on same-address read/write collisions.
module dual_ram #(
  parameter int RAM_WIDTH = 8,
  parameter int RAM_DEPTH = 16,
  parameter int ADDR_SIZE = 4
) (
  input  logic                 clk,
  input  logic                 read,
  input  logic                 write,
  input  logic                 reset,
  input  logic [ADDR_SIZE-1:0] rd_addr,
  input  logic [ADDR_SIZE-1:0] wr_addr,
  input  logic [RAM_WIDTH-1:0] data_in,
  output logic [RAM_WIDTH-1:0] data_out
);

  // One extra bit so RAM_DEPTH == 2**ADDR_SIZE is still representable.
  localparam logic [ADDR_SIZE:0] DEPTH_L = (ADDR_SIZE + 1)'(RAM_DEPTH);

  logic [RAM_WIDTH-1:0] mem_q [RAM_DEPTH];
  logic [RAM_WIDTH-1:0] data_q;
  logic [RAM_WIDTH-1:0] data_d;
  logic [RAM_DEPTH-1:0] wr_sel;
  logic                 wr_ok;
  logic                 rd_ok;

  assign wr_ok = ({1'b0, wr_addr} < DEPTH_L);
  assign rd_ok = ({1'b0, rd_addr} < DEPTH_L);

  genvar gi;
  generate
    for (gi = 0; gi < RAM_DEPTH; gi++) begin : g_wr_dec
      localparam logic [ADDR_SIZE-1:0] IDX = ADDR_SIZE'(gi);
      assign wr_sel[gi] = write && wr_ok && (wr_addr == IDX);
    end
  endgenerate

  always_comb begin
    data_d = data_q;
    if (read) begin
      if (!rd_ok) begin
        data_d = '0;
      end else begin
        data_d = mem_q[rd_addr];
`ifdef DUAL_RAM_BYPASS_EN
        if (write && wr_ok && (wr_addr == rd_addr)) begin
          data_d = data_in;
        end
`endif
      end
    end
  end

  // Reset clears every word so no location ever reads back X.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < RAM_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      data_q <= '0;
    end else begin
      for (int i = 0; i < RAM_DEPTH; i++) begin
        if (wr_sel[i]) begin
          mem_q[i] <= data_in;
        end
      end
      data_q <= data_d;
    end
  end

  assign data_out = data_q;

endmodule

// File: tb/tb_dual_ram.sv
// Self-checking bench for dual_ram: directed vector table plus randomized traffic against an array model.
module tb_dual_ram;

`ifdef DUAL_RAM_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       read = 1'b0;
  logic       write = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] rd_addr = '0;
  logic [3:0] wr_addr = '0;
  logic [7:0] data_in = '0;
  logic [7:0] data_out;

  int n_vec = 0;
  int n_bad = 0;

  dual_ram #(.RAM_WIDTH(8), .RAM_DEPTH(16), .ADDR_SIZE(4)) dut (
    .clk(clk), .read(read), .write(write), .reset(reset),
    .rd_addr(rd_addr), .wr_addr(wr_addr), .data_in(data_in), .data_out(data_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       rd;
    logic       wr;
    logic [3:0] ra;
    logic [3:0] wa;
    logic [7:0] din;
    logic [7:0] exp;
    string      name;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic rst_n, rd, wr, input logic [3:0] ra, wa,
                              input logic [7:0] din, exp, input string name);
    vec_t v;
    v.rst_n = rst_n; v.rd = rd; v.wr = wr; v.ra = ra; v.wa = wa;
    v.din = din; v.exp = exp; v.name = name;
    tbl.push_back(v);
  endfunction

  // Drive one cycle's inputs, let the edge happen, then compare data_out after it.
  task automatic apply(input logic rst_n, rd, wr, input logic [3:0] ra, wa,
                       input logic [7:0] din, exp, input string name);
    reset = rst_n; read = rd; write = wr;
    rd_addr = ra; wr_addr = wa; data_in = din;
    @(posedge clk);
    #1;
    n_vec++;
    if (data_out !== exp) begin
      n_bad++;
      $display("FAIL %s: data_out=%02h required %02h", name, data_out, exp);
    end else begin
      $display("ok   %s: data_out=%02h", name, data_out);
    end
  endtask

  logic [7:0] mem_m [16];
  logic [7:0] dout_m;

  task automatic model_step(input logic rst_n, rd, wr, input logic [3:0] ra, wa,
                            input logic [7:0] din);
    if (!rst_n) begin
      foreach (mem_m[i]) mem_m[i] = 8'h00;
      dout_m = 8'h00;
    end else begin
      if (rd) dout_m = (BYP && wr && (ra == wa)) ? din : mem_m[ra];
      if (wr) mem_m[wa] = din;
    end
  endtask

  task automatic rand_cycle(input logic rst_n, rd, wr, input logic [3:0] ra, wa,
                            input logic [7:0] din, input string name);
    model_step(rst_n, rd, wr, ra, wa, din);
    apply(rst_n, rd, wr, ra, wa, din, dout_m, name);
  endtask

  initial begin
    // Reset state, with a write in the same cycle that must be discarded.
    add(1'b0, 1'b0, 1'b1, 4'd0, 4'd9, 8'h77, 8'h00, "reset_prio");
    add(1'b1, 1'b1, 1'b0, 4'd9, 4'd0, 8'h00, 8'h00, "reset_prio_rd9");
    add(1'b1, 1'b0, 1'b1, 4'd0, 4'd3, 8'hA5, 8'h00, "wr3");
    add(1'b1, 1'b0, 1'b1, 4'd0, 4'd7, 8'h3C, 8'h00, "wr7");
    add(1'b1, 1'b0, 1'b1, 4'd0, 4'd15, 8'hFF, 8'h00, "wr15");
    add(1'b1, 1'b1, 1'b0, 4'd3, 4'd0, 8'h00, 8'hA5, "rd3");
    add(1'b1, 1'b1, 1'b0, 4'd7, 4'd0, 8'h00, 8'h3C, "rd7");
    add(1'b1, 1'b1, 1'b0, 4'd15, 4'd0, 8'h00, 8'hFF, "rd15");
    add(1'b1, 1'b1, 1'b0, 4'd3, 4'd0, 8'h00, 8'hA5, "rd3_again");
    add(1'b1, 1'b0, 1'b0, 4'd7, 4'd0, 8'h00, 8'hA5, "hold_rd0");
    add(1'b1, 1'b0, 1'b0, 4'd0, 4'd3, 8'h11, 8'hA5, "ignore_wr0");
    add(1'b1, 1'b1, 1'b0, 4'd7, 4'd0, 8'h00, 8'h3C, "rd7_mid");
    add(1'b1, 1'b1, 1'b0, 4'd3, 4'd0, 8'h00, 8'hA5, "rd3_after_wr0");
    add(1'b1, 1'b0, 1'b1, 4'd0, 4'd5, 8'h12, 8'hA5, "wr5");
    add(1'b1, 1'b1, 1'b1, 4'd5, 4'd5, 8'h34, BYP ? 8'h34 : 8'h12, "collide5");
    add(1'b1, 1'b1, 1'b0, 4'd5, 4'd0, 8'h00, 8'h34, "rd5_after_collide");
    add(1'b1, 1'b0, 1'b1, 4'd0, 4'd6, 8'h56, 8'h34, "wr6");
    add(1'b1, 1'b1, 1'b0, 4'd6, 4'd0, 8'h00, 8'h56, "rd6_b2b");
    add(1'b1, 1'b1, 1'b1, 4'd7, 4'd2, 8'h99, 8'h3C, "rd7_wr2");
    add(1'b1, 1'b1, 1'b0, 4'd2, 4'd0, 8'h00, 8'h99, "rd2");
    add(1'b1, 1'b1, 1'b1, 4'd2, 4'd2, 8'h66, BYP ? 8'h66 : 8'h99, "collide2");
    add(1'b0, 1'b1, 1'b1, 4'd2, 4'd4, 8'hEE, 8'h00, "mid_reset");
    add(1'b1, 1'b1, 1'b0, 4'd3, 4'd0, 8'h00, 8'h00, "rd3_post_reset");
    add(1'b1, 1'b1, 1'b0, 4'd4, 4'd0, 8'h00, 8'h00, "rd4_post_reset");

    // Reset then read every address.
    apply(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 8'h00, 8'h00, "init_reset");
    for (int a = 0; a < 16; a++) begin
      apply(1'b1, 1'b1, 1'b0, 4'(a), 4'd0, 8'h00, 8'h00, $sformatf("rst_rd%0d", a));
    end

    foreach (tbl[i]) begin
      apply(tbl[i].rst_n, tbl[i].rd, tbl[i].wr, tbl[i].ra, tbl[i].wa,
            tbl[i].din, tbl[i].exp, tbl[i].name);
    end

    // Random: reset, 10 writes, 10 reads, then mixed traffic.
    rand_cycle(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 8'h00, "rnd_reset");
    for (int i = 0; i < 10; i++) begin
      rand_cycle(1'b1, 1'b0, 1'b1, 4'd0, 4'($urandom % 16), 8'($urandom % 256),
                 $sformatf("rnd_wr%0d", i));
    end
    for (int i = 0; i < 10; i++) begin
      rand_cycle(1'b1, 1'b1, 1'b0, 4'($urandom % 16), 4'd0, 8'h00,
                 $sformatf("rnd_rd%0d", i));
    end
    for (int i = 0; i < 200; i++) begin
      rand_cycle(($urandom % 40) != 0, 1'($urandom), 1'($urandom),
                 4'($urandom % 16), 4'($urandom % 16), 8'($urandom % 256),
                 $sformatf("rnd_mix%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/dual_ram.md
Name: dual_ram

Overview:
- Simple dual-port synchronous RAM: one write port and one independent read port, on a single clock.
- Used as a generic small storage block, e.g. a register file or FIFO backing store.
- Write and read addresses are separate, so one write and one read can occur in the same cycle.

Parameters:
- RAM_WIDTH, 8, data word width in bits.
- RAM_DEPTH, 16, number of words; must be ≤ 2**ADDR_SIZE.
- ADDR_SIZE, 4, width of rd_addr and wr_addr in bits.

Ports:
- clk  input  1  clock; all activity on the rising edge.
- reset  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- read  input  1  read enable, active-high.
- write  input  1  write enable, active-high.
- rd_addr  input  ADDR_SIZE  read address.
- wr_addr  input  ADDR_SIZE  write address.
- data_in  input  RAM_WIDTH  write data.
- data_out  output  RAM_WIDTH  registered read data.

Instantiation order is clk, read, write, reset, rd_addr, wr_addr, data_in, data_out; positional connection must work.

Behaviour:
- Reset: reset is synchronous and active-low.
  - On a rising edge with reset=0, all RAM_DEPTH locations are cleared to 0 and data_out is cleared to 0.
  - Reset overrides read and write; a write in a reset cycle is discarded.
- Write: on a rising edge with reset=1, write=1 and wr_addr < RAM_DEPTH, mem[wr_addr] ← data_in.
  - Writes with wr_addr ≥ RAM_DEPTH are ignored.
  - With write=0, memory is unchanged.
- Read: on a rising edge with reset=1 and read=1, data_out ← mem[rd_addr].
  - The value is visible after that edge, i.e. one-cycle latency.
  - rd_addr ≥ RAM_DEPTH loads 0.
  - With read=0, data_out holds its previous value.
- Simultaneous read and write, different addresses: both complete independently in the same cycle.
- Simultaneous read and write, same address: read-before-write by default. data_out gets the old contents and the memory gets data_in. See Optional Feature for the alternative.
- Back-to-back operations:
  - Writes may occur on every cycle.
  - A read in the cycle after a write to the same address returns the new data.
- Reset asserted mid-stream: contents are lost and data_out=0 after the edge.
  - Reads after reset release return 0 until the location is written.
- No X propagation after the first reset: every location has a defined value.
- Storage is an array indexed by address, with no internal handshake.
- Throughput is one write plus one read per cycle.

Optional Feature:
- Macro DUAL_RAM_BYPASS_EN.
- When defined: write-first forwarding. If read=1, write=1 and rd_addr==wr_addr (both < RAM_DEPTH) in the same cycle, data_out ← data_in.
- When undefined: read-before-write as above, so data_out gets the old mem contents.
- Memory update is identical in both builds.

Test Plan:
- Reset then read: drive reset=0 for one edge, then reset=1, and read addresses 0..15. Required: data_out=0x00 for every address, one cycle after each read.
- Write/read-back: write 0xA5@3, 0x3C@7, 0xFF@15, then read 3, 7, 15. Required: data_out = 0xA5, 0x3C, 0xFF, each one cycle after its read.
- Hold and ignore:
  - read=0 after reading 0xA5: data_out stays 0xA5.
  - write=0 with data_in=0x11 at wr_addr=3: a later read of 3 still returns 0xA5.
- Same-address collision: mem[5]=0x12, then one cycle with write=1, read=1, addr 5, data_in=0x34. Required:
  - data_out=0x12 without DUAL_RAM_BYPASS_EN.
  - data_out=0x34 with DUAL_RAM_BYPASS_EN.
  - A next read of 5 returns 0x34 in both builds.
- Reset priority: write 0x77@9 with reset=0 in the same cycle, then release reset and read 9. Required: data_out=0x00.
- Random: 10 random writes (data %256, addr %16) followed by 10 random reads, checked against a reference model. Required: every read matches the model; never-written addresses read 0.
